// File: rtl/bbox_tracker.sv
// bbox_tracker: per-frame ROI-clamped, margin-expanded bounding box of thresholded pixels
module bbox_tracker #(
    parameter int DATA_W    = 8,
    parameter int X_W       = 11,
    parameter int Y_W       = 10,
    parameter int ROI_X0    = 440,
    parameter int ROI_X1    = 840,
    parameter int ROI_Y0    = 120,
    parameter int ROI_Y1    = 600,
    parameter int THRESH    = 200,
    parameter int POLARITY  = 0,
    parameter int MARGIN    = 10,
    parameter int MIN_COUNT = 1,
    parameter int CNT_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic [X_W-1:0]    pix_x,
    input  logic [Y_W-1:0]    pix_y,
    output logic [X_W-1:0]    box_left,
    output logic [X_W-1:0]    box_right,
    output logic [Y_W-1:0]    box_top,
    output logic [Y_W-1:0]    box_bottom,
    output logic              obj_found,
    output logic              box_valid
);
    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;
    localparam logic [X_W-1:0] RX0 = X_W'(ROI_X0);
    localparam logic [X_W-1:0] RX1 = X_W'(ROI_X1);
    localparam logic [Y_W-1:0] RY0 = Y_W'(ROI_Y0);
    localparam logic [Y_W-1:0] RY1 = Y_W'(ROI_Y1);
    localparam logic [X_W-1:0] MX = X_W'(MARGIN);
    localparam logic [Y_W-1:0] MY = Y_W'(MARGIN);
    localparam logic [XW1-1:0] XLO = XW1'(ROI_X0 + MARGIN);
    localparam logic [XW1-1:0] XHI = XW1'(ROI_X1);
    localparam logic [XW1-1:0] XME = XW1'(MARGIN);
    localparam logic [YW1-1:0] YLO = YW1'(ROI_Y0 + MARGIN);
    localparam logic [YW1-1:0] YHI = YW1'(ROI_Y1);
    localparam logic [YW1-1:0] YME = YW1'(MARGIN);
    localparam logic [DATA_W-1:0] TH = DATA_W'(THRESH);
    localparam logic [CNT_W-1:0] MINC = CNT_W'(MIN_COUNT);

    typedef enum logic [1:0] {WAIT_SOF, ACCUM, REPORT} state_t;
    state_t state, state_nx;

    logic [X_W-1:0]   min_x, max_x, nmin_x, nmax_x, left_nx, right_nx;
    logic [Y_W-1:0]   min_y, max_y, nmin_y, nmax_y, top_nx, bottom_nx;
    logic [CNT_W-1:0] count, ncount;
    logic             sof, eof, in_roi, fg, take, hit, last, found_nx;

    // pixel classification and next accumulator values including the current pixel
    always_comb begin
        sof       = pix_x == RX0 && pix_y == RY0;
        eof       = pix_x == RX1 && pix_y == RY1;
        in_roi    = pix_x >= RX0 && pix_x <= RX1 && pix_y >= RY0 && pix_y <= RY1;
        fg        = (POLARITY != 0) ? pix_data >= TH : pix_data < TH;
        take      = pix_valid && (state == ACCUM || (state == WAIT_SOF && sof));
        hit       = take && in_roi && fg;
        last      = take && state == ACCUM && eof;
        nmin_x    = (hit && pix_x < min_x) ? pix_x : min_x;
        nmax_x    = (hit && pix_x > max_x) ? pix_x : max_x;
        nmin_y    = (hit && pix_y < min_y) ? pix_y : min_y;
        nmax_y    = (hit && pix_y > max_y) ? pix_y : max_y;
        ncount    = (hit && count != '1) ? count + 1'b1 : count;
        found_nx  = ncount >= MINC;
        left_nx   = ({1'b0, nmin_x} >= XLO) ? nmin_x - MX : RX0;
        right_nx  = ({1'b0, nmax_x} + XME <= XHI) ? nmax_x + MX : RX1;
        top_nx    = ({1'b0, nmin_y} >= YLO) ? nmin_y - MY : RY0;
        bottom_nx = ({1'b0, nmax_y} + YME <= YHI) ? nmax_y + MY : RY1;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_SOF;
        else     state <= state_nx;
    end

    // next state: align on first ROI pixel, report after last ROI pixel
    always_comb begin
        state_nx = (state == REPORT) ? WAIT_SOF : last ? REPORT : take ? ACCUM : state;
    end

    // strobe is high for the single REPORT cycle
    always_comb begin
        box_valid = state == REPORT;
    end

    // accumulators clear on reset and when a frame is handed off for reporting
    always_ff @(posedge clk) begin
        if (rst || last) begin
            min_x <= RX1;
            max_x <= RX0;
            min_y <= RY1;
            max_y <= RY0;
            count <= '0;
        end else begin
            min_x <= nmin_x;
            max_x <= nmax_x;
            min_y <= nmin_y;
            max_y <= nmax_y;
            count <= ncount;
        end
    end

    // published box holds unless the finished frame contained an object
    always_ff @(posedge clk) begin
        if (rst) begin
            box_left   <= '0;
            box_right  <= '0;
            box_top    <= '0;
            box_bottom <= '0;
            obj_found  <= 1'b0;
        end else if (last) begin
            obj_found <= found_nx;
            if (found_nx) begin
                box_left   <= left_nx;
                box_right  <= right_nx;
                box_top    <= top_nx;
                box_bottom <= bottom_nx;
            end
        end
    end
endmodule

// File: tb/tb_bbox_tracker.sv
// tb_bbox_tracker: directed frame-level checks of bbox_tracker
module tb_bbox_tracker;
    logic        clk = 0;
    logic        rst;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [10:0] la, ra, lb, rb, lc, rc;
    logic [9:0]  ta, ba, tb, bb, tc, bc;
    logic        fa, va, fb, vb, fc, vc;
    int total = 0;
    int bad = 0;
    logic va_p, va_e, va_n, vb_e, vc_e, vc_n;

    typedef struct {int x; int y; int d;} pix_t;
    pix_t q[$];

    always #5 clk = ~clk;

    bbox_tracker dut_a (.clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .box_left(la), .box_right(ra), .box_top(ta),
        .box_bottom(ba), .obj_found(fa), .box_valid(va));
    bbox_tracker #(.MIN_COUNT(4)) dut_b (.clk(clk), .rst(rst), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .box_left(lb), .box_right(rb),
        .box_top(tb), .box_bottom(bb), .obj_found(fb), .box_valid(vb));
    bbox_tracker #(.POLARITY(1)) dut_c (.clk(clk), .rst(rst), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .box_left(lc), .box_right(rc),
        .box_top(tc), .box_bottom(bc), .obj_found(fc), .box_valid(vc));

    task automatic send(input int x, input int y, input int d);
        pix_valid = 1;
        pix_x = 11'(x);
        pix_y = 10'(y);
        pix_data = 8'(d);
        @(posedge clk);
        #1;
        pix_valid = 0;
    endtask

    task automatic idle();
        pix_valid = 0;
        pix_x = 11'd840;
        pix_y = 10'd600;
        pix_data = 8'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int bg, input bit gaps);
        send(440, 120, bg);
        foreach (q[i]) begin
            if (gaps && $urandom_range(99) < 30) idle();
            send(q[i].x, q[i].y, q[i].d);
        end
        if (gaps) idle();
        send(600, 300, bg);
        va_p = va;
        if (gaps && $urandom_range(99) < 30) idle();
        send(840, 600, bg);
        va_e = va;
        vb_e = vb;
        vc_e = vc;
        idle();
        va_n = va;
        vc_n = vc;
    endtask

    task automatic test_reset();
        total++;
        if ({la, ra, ta, ba, fa, va} !== '0) begin
            bad++;
            $display("FAIL reset_a got=%h want=0", {la, ra, ta, ba, fa, va});
        end
        total++;
        if ({lb, rb, tb, bb, fb, vb, lc, rc, tc, bc, fc, vc} !== '0) begin
            bad++;
            $display("FAIL reset_bc got=%h want=0", {lb, rb, tb, bb, fb, vb, lc, rc, tc, bc, fc, vc});
        end
    endtask

    task automatic test_single();
        q = {};
        q.push_back('{500, 300, 10});
        run_frame(255, 0);
        total++;
        if ({va_p, va_e, va_n} !== 3'b010) begin
            bad++;
            $display("FAIL single_strobe got=%b want=010", {va_p, va_e, va_n});
        end
        total++;
        if ({la, ra, ta, ba} !== {11'd490, 11'd510, 10'd290, 10'd310}) begin
            bad++;
            $display("FAIL single_box got=%0d,%0d,%0d,%0d want=490,510,290,310", la, ra, ta, ba);
        end
        total++;
        if (fa !== 1'b1) begin
            bad++;
            $display("FAIL single_found got=%b want=1", fa);
        end
    endtask

    task automatic test_clamp();
        q = {};
        q.push_back('{445, 125, 10});
        q.push_back('{835, 595, 10});
        run_frame(255, 0);
        total++;
        if ({va_e, fa} !== 2'b11) begin
            bad++;
            $display("FAIL clamp_valid_found got=%b want=11", {va_e, fa});
        end
        total++;
        if ({la, ra, ta, ba} !== {11'd440, 11'd840, 10'd120, 10'd600}) begin
            bad++;
            $display("FAIL clamp_box got=%0d,%0d,%0d,%0d want=440,840,120,600", la, ra, ta, ba);
        end
    endtask

    task automatic test_empty();
        q = {};
        run_frame(255, 0);
        total++;
        if ({va_e, va_n, fa} !== 3'b100) begin
            bad++;
            $display("FAIL empty_valid_found got=%b want=100", {va_e, va_n, fa});
        end
        total++;
        if ({la, ra, ta, ba} !== {11'd440, 11'd840, 10'd120, 10'd600}) begin
            bad++;
            $display("FAIL empty_box_hold got=%0d,%0d,%0d,%0d want=440,840,120,600", la, ra, ta, ba);
        end
    endtask

    task automatic test_outside_and_count();
        q = {};
        q.push_back('{100, 50, 10});
        q.push_back('{900, 700, 10});
        run_frame(255, 0);
        total++;
        if ({va_e, fa} !== 2'b10) begin
            bad++;
            $display("FAIL outside_found got=%b want=10", {va_e, fa});
        end
        total++;
        if ({la, ra, ta, ba} !== {11'd440, 11'd840, 10'd120, 10'd600}) begin
            bad++;
            $display("FAIL outside_box got=%0d,%0d,%0d,%0d want=440,840,120,600", la, ra, ta, ba);
        end
        q = {};
        for (int i = 0; i < 3; i++) q.push_back('{600, 400 + i, 10});
        run_frame(255, 0);
        total++;
        if ({vb_e, fb} !== 2'b10) begin
            bad++;
            $display("FAIL count3_found got=%b want=10", {vb_e, fb});
        end
        total++;
        if ({lb, rb, tb, bb} !== '0) begin
            bad++;
            $display("FAIL count3_box got=%0d,%0d,%0d,%0d want=0,0,0,0", lb, rb, tb, bb);
        end
        q.push_back('{600, 403, 10});
        run_frame(255, 0);
        total++;
        if ({vb_e, fb} !== 2'b11) begin
            bad++;
            $display("FAIL count4_found got=%b want=11", {vb_e, fb});
        end
        total++;
        if ({lb, rb, tb, bb} !== {11'd590, 11'd610, 10'd390, 10'd413}) begin
            bad++;
            $display("FAIL count4_box got=%0d,%0d,%0d,%0d want=590,610,390,413", lb, rb, tb, bb);
        end
    endtask

    task automatic test_mid_reset();
        send(440, 120, 255);
        send(500, 200, 10);
        send(600, 300, 10);
        send(700, 350, 255);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        total++;
        if ({la, ra, ta, ba, fa, va} !== '0) begin
            bad++;
            $display("FAIL midrst_clear got=%h want=0", {la, ra, ta, ba, fa, va});
        end
        send(800, 400, 10);
        send(840, 600, 255);
        total++;
        if ({la, ra, ta, ba, fa, va} !== '0) begin
            bad++;
            $display("FAIL midrst_no_report got=%h want=0", {la, ra, ta, ba, fa, va});
        end
        idle();
        total++;
        if (va !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_strobe got=%b want=0", va);
        end
        q = {};
        q.push_back('{700, 500, 10});
        run_frame(255, 0);
        total++;
        if ({va_e, fa} !== 2'b11) begin
            bad++;
            $display("FAIL midrst_next_found got=%b want=11", {va_e, fa});
        end
        total++;
        if ({la, ra, ta, ba} !== {11'd690, 11'd710, 10'd490, 10'd510}) begin
            bad++;
            $display("FAIL midrst_next_box got=%0d,%0d,%0d,%0d want=690,710,490,510", la, ra, ta, ba);
        end
    endtask

    task automatic test_gaps_polarity();
        for (int g = 0; g < 2; g++) begin
            q = {};
            q.push_back('{600, 200, 220});
            q.push_back('{700, 250, 100});
            q.push_back('{620, 210, 150});
            run_frame(100, g != 0);
            total++;
            if ({vc_e, vc_n, fc} !== 3'b101) begin
                bad++;
                $display("FAIL bright_gaps%0d_found got=%b want=101", g, {vc_e, vc_n, fc});
            end
            total++;
            if ({lc, rc, tc, bc} !== {11'd590, 11'd610, 10'd190, 10'd210}) begin
                bad++;
                $display("FAIL bright_gaps%0d_box got=%0d,%0d,%0d,%0d want=590,610,190,210", g, lc, rc, tc, bc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        pix_valid = 0;
        pix_data = 0;
        pix_x = 0;
        pix_y = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        test_reset();
        test_single();
        test_clamp();
        test_empty();
        test_outside_and_count();
        test_mid_reset();
        test_gaps_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
